pipe_mux_n: RTL and testbench
=============================

// Module: pipe_mux_n
// PURPOSE
//   Parametrised N-to-1 datapath selector with a registered, elastic output stage.
//   Selects one of N WIDTH-bit inputs, then carries the result, its select code and
//   an error flag through a 2-entry skid buffer with valid/ready handshakes.
//   Used between pipeline stages (forwarding/writeback select) where the downstream stage can stall.
//   Supports flush and out-of-range select detection.
// PARAMETERS
//   WIDTH  32              data width per input
//   N      8               number of inputs, 2..64
//   SEL_W  $clog2(N)       select width (derived; do not override)
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   flush      in   1        synchronous pipeline flush
//   in_data    in   N*WIDTH  packed inputs; input k = in_data[k*WIDTH +: WIDTH]
//   in_sel     in   SEL_W    select code
//   in_valid   in   1        upstream beat valid
//   in_ready   out  1        block can accept a beat
//   out_data   out  WIDTH    selected data, registered
//   out_sel    out  SEL_W    select code that produced out_data
//   out_err    out  1        beat had in_sel >= N
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts beat
// BEHAVIOUR
//   - Reset (async, rst=1): state EMPTY, out_valid=0, in_ready=1, out_data=0, out_sel=0,
//     out_err=0, skid contents=0. Reset may assert mid-transfer; in-flight beats are discarded.
//   - accept = in_valid & in_ready; fire = out_valid & out_ready.
//   - Select: in_sel < N -> input in_sel; in_sel >= N -> data 0, err=1 (only reachable if N is not 2^k).
//   - Latency: accepted beat appears on out_* on the next cycle when the output register is free.
//   - Storage: main register (drives out_*) + skid register. in_ready is a registered output,
//     1 unless state FULL; no combinational path from out_ready to in_ready.
//   - States:
//       EMPTY: accept -> main<=beat, ONE.
//       ONE:   accept & fire  -> main<=beat, stay ONE.
//              accept & !fire -> skid<=beat, FULL.
//              !accept & fire -> EMPTY.  Otherwise hold.
//       FULL:  in_ready=0; fire -> main<=skid, ONE; otherwise hold.
//   - out_valid = (state != EMPTY). out_data/out_sel/out_err hold stable while
//     out_valid & !out_ready (no change until fire).
//   - flush (sync): highest priority after rst; next state EMPTY, out_valid=0, in_ready=1;
//     beat presented in the flush cycle is not accepted. out_data keeps its last value.
//   - Order preserved: beats leave in acceptance order; no beat dropped or duplicated.
//   - in_data/in_sel are sampled only on accept; values are don't-care otherwise.
// TESTING
//   1 rst=1 mid-run -> out_valid=0, in_ready=1, out_data=0 immediately (before clk edge).
//   2 N=8, inputs k=0x1000+k, sel=5, valid 1 cycle, out_ready=1 -> next cycle out_data=0x1005,
//     out_sel=5, out_valid=1, out_err=0.
//   3 out_ready=0, send sels 2,3,4 back-to-back -> 2 in main, 3 in skid, in_ready=0 after 2nd
//     beat, sel 4 not accepted; raise out_ready -> outputs 0x1002,0x1003 in order, then 4 accepted.
//   4 Continuous stream, out_ready=1 -> one beat per cycle, in_ready stays 1, sels 0..7 in order.
//   5 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, neither
//     buffered beat nor the flush-cycle beat ever appears.
//   6 N=6, sel=7 -> out_data=0, out_err=1; following sel=1 -> out_err=0, out_data=input 1.
//   Random stall/valid with scoreboard: output sequence equals accepted sequence.

Source files
------------

// File: rtl/pipe_mux_n.sv
// N-to-1 datapath selector feeding a registered 2-entry skid buffer.
// The upstream and downstream sides use valid/ready handshakes. Flush empties the buffer.
module pipe_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_err;

    logic [WIDTH-1:0] sel_data_p0;
    logic             sel_err_p0;
    logic             accept;
    logic             fire;

    // Returns {err, data}. Any code that matches no input yields data 0 with err set.
    function automatic logic [WIDTH:0] select_beat(input logic [N*WIDTH-1:0] data,
                                                   input logic [SEL_W-1:0]   sel);
        logic [WIDTH:0] r;
        r = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                r = {1'b0, data[k*WIDTH +: WIDTH]};
            end
        end
        return r;
    endfunction

    assign {sel_err_p0, sel_data_p0} = select_beat(in_data, in_sel);

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // Stage p0 -> p1: main register drives out_*, and the skid register catches a beat while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= sel_data_p0;
                        out_sel   <= in_sel;
                        out_err   <= sel_err_p0;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        out_data <= sel_data_p0;
                        out_sel  <= in_sel;
                        out_err  <= sel_err_p0;
                    end else if (accept) begin
                        skid_data <= sel_data_p0;
                        skid_sel  <= in_sel;
                        skid_err  <= sel_err_p0;
                        state     <= FULL;
                        in_ready  <= 1'b0;
                    end else if (fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        out_data <= skid_data;
                        out_sel  <= skid_sel;
                        out_err  <= skid_err;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n. It runs directed steps and then a random stall/valid stream.
// The reference model is a FIFO of beats with at most two entries.
module tb_pipe_mux_n;

    localparam int WIDTH = 32;
    localparam int N     = 8;
    localparam int SEL_W = 3;
    localparam int N6    = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    logic [N6*WIDTH-1:0] d6_in_data;
    logic [2:0]          d6_in_sel;
    logic                d6_in_valid;
    logic                d6_in_ready;
    logic [WIDTH-1:0]    d6_out_data;
    logic [2:0]          d6_out_sel;
    logic                d6_out_err;
    logic                d6_out_valid;
    logic                d6_out_ready;

    pipe_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    pipe_mux_n #(.WIDTH(WIDTH), .N(N6)) dut6 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_data(d6_in_data), .in_sel(d6_in_sel), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
        .out_data(d6_out_data), .out_sel(d6_out_sel), .out_err(d6_out_err),
        .out_valid(d6_out_valid), .out_ready(d6_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [SEL_W-1:0] s;
        logic             e;
    } beat_t;

    beat_t            q[$];
    logic [WIDTH-1:0] word[N];
    int               vectors = 0;
    int               errors  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_words();
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = word[k];
    endtask

    task automatic check_model();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_sel", 64'(out_sel), 64'(q[0].s));
            chk("out_err", 64'(out_err), 64'(q[0].e));
        end
    endtask

    // One clock: decide accept/fire from the model, advance the model at the edge, then compare.
    task automatic cycle();
        bit    acc;
        bit    fire;
        beat_t b;
        acc  = in_valid && (q.size() < 2);
        fire = (q.size() > 0) && out_ready;
        b.d  = word[in_sel];
        b.s  = in_sel;
        b.e  = 1'b0;  // N=8 covers every 3-bit code
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        d6_in_valid = 1'b0; d6_in_sel = '0; d6_out_ready = 1'b0;
        for (int k = 0; k < N; k++) word[k] = 32'h1000 + 32'(k);
        for (int k = 0; k < N6; k++) d6_in_data[k*WIDTH +: WIDTH] = 32'h2000 + 32'(k);
        pack_words();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Single beat, sel 5
        out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd5;
        cycle();
        chk("t2_data", 64'(out_data), 64'h1005);
        chk("t2_sel", 64'(out_sel), 64'd5);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_err", 64'(out_err), 64'd0);
        in_valid = 1'b0;
        cycle();

        // Back-to-back beats into a stalled output
        out_ready = 1'b0; in_valid = 1'b1;
        in_sel = 3'd2; cycle();
        in_sel = 3'd3; cycle();
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        in_sel = 3'd4; cycle();
        cycle();
        chk("t3_hold_data", 64'(out_data), 64'h1002);
        out_ready = 1'b1;
        cycle();
        chk("t3_second_out", 64'(out_data), 64'h1003);
        cycle();
        chk("t3_third_out", 64'(out_data), 64'h1004);
        in_valid = 1'b0;
        cycle();
        cycle();

        // Continuous stream at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            cycle();
            chk("t4_stream_sel", 64'(out_sel), 64'(s));
        end
        in_valid = 1'b0;
        cycle();

        // Flush while full, with a beat presented in the flush cycle
        out_ready = 1'b0; in_valid = 1'b1;
        in_sel = 3'd6; cycle();
        in_sel = 3'd7; cycle();
        flush = 1'b1; in_sel = 3'd1;
        cycle();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b1; in_sel = 3'd3;
        cycle();
        in_valid = 1'b0;
        cycle();

        // Asynchronous reset while a beat is held
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd4;
        cycle();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_out_data", 64'(out_data), 64'd0);
        q.delete();
        @(negedge clk) rst = 1'b0;

        // Out-of-range select on the N=6 instance
        d6_out_ready = 1'b1; d6_in_valid = 1'b1; d6_in_sel = 3'd7;
        @(posedge clk); #1;
        chk("t6_err_data", 64'(d6_out_data), 64'd0);
        chk("t6_err_flag", 64'(d6_out_err), 64'd1);
        chk("t6_err_sel", 64'(d6_out_sel), 64'd7);
        chk("t6_err_valid", 64'(d6_out_valid), 64'd1);
        d6_in_sel = 3'd1;
        @(posedge clk); #1;
        chk("t6_ok_data", 64'(d6_out_data), 64'h2001);
        chk("t6_ok_flag", 64'(d6_out_err), 64'd0);
        d6_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_drained", 64'(d6_out_valid), 64'd0);

        // Random valid/stall/flush stream against the FIFO model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            in_sel    = 3'($urandom % 8);
            for (int k = 0; k < N; k++) word[k] = $urandom;
            pack_words();
            cycle();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
